// File: rtl/tea_pkg.sv
// Shared TEA definitions used by the encrypt and decrypt cores.
// Contents: FSM state encoding, the key-schedule constant and the round mixing function.
package tea_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } tea_state_e;

    localparam logic [31:0] TEA_DELTA = 32'h9E3779B9;

    // F(v) = ((v<<4)+ka) ^ (v+sum) ^ ((v>>5)+kb); logical shift, all mod 2^32
    function automatic logic [31:0] tea_mix(
        input logic [31:0] v,
        input logic [31:0] sum,
        input logic [31:0] ka,
        input logic [31:0] kb
    );
        return ((v << 4) + ka) ^ (v + sum) ^ ((v >> 5) + kb);
    endfunction

endpackage

// File: rtl/tea_decrypt_core_mod33down.sv
// Remaining-round counter for the decrypt core: 6-bit load / decrement with a zero flag.
// Clear has priority over load, and load has priority over decrement.
module mod33down (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic [5:0] load_val_i,
    input  logic       dec_i,
    input  logic       clr_i,
    output logic [5:0] cnt_o,
    output logic       zero_o
);

    logic [5:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i) begin
            cnt_d = cnt_q - 6'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == 6'd0);

endmodule

// File: rtl/tea_decrypt_core.sv
// TEA decryption core: iterative, one full round per clock, ROUNDS rounds per block.
// The optional ABORT input is compiled in with `define TEA_DECRYPT_ABORT_EN.
module tea_decrypt_core
    import tea_pkg::*;
#(
    parameter int          ROUNDS = 32,
    parameter logic [31:0] DELTA  = TEA_DELTA
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         START,
`ifdef TEA_DECRYPT_ABORT_EN
    input  logic         ABORT,
`endif
    input  logic [127:0] KEY,
    input  logic [63:0]  CIN,
    output logic         READY,
    output logic         BUSY,
    output logic         DONE,
    output logic [63:0]  POUT,
    output logic [5:0]   ROUND
);

    localparam logic [31:0] SUM_INIT   = DELTA * 32'(ROUNDS);
    localparam logic [5:0]  ROUND_INIT = 6'(ROUNDS);

    tea_state_e   state_q, state_d;
    logic [31:0]  v0_q, v1_q, sum_q;
    logic [31:0]  v0_d, v1_d;
    logic [127:0] key_q;
    logic [63:0]  pout_q;
    logic [5:0]   round_w;
    logic         abort_w, load_w, last_w, fin_w, clr_w, dec_w, zero_w;

`ifdef TEA_DECRYPT_ABORT_EN
    assign abort_w = ABORT;
`else
    assign abort_w = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (START) state_d = ST_RUN;
            ST_RUN: begin
                if (abort_w) begin
                    state_d = ST_IDLE;
                end else if (last_w) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        READY = 1'b0;
        BUSY  = 1'b0;
        DONE  = 1'b0;
        case (state_q)
            ST_IDLE: READY = 1'b1;
            ST_RUN:  BUSY  = 1'b1;
            ST_FIN:  DONE  = 1'b1;
            default: ;
        endcase
    end

    assign load_w = READY & START;
    assign last_w = (round_w == 6'd1);
    assign fin_w  = BUSY & ~abort_w & last_w;
    assign clr_w  = BUSY & abort_w;
    assign dec_w  = BUSY & ~zero_w;

    mod33down u_round_cnt (
        .clk_i      (CLK),
        .rst_ni     (RST_N),
        .load_i     (load_w),
        .load_val_i (ROUND_INIT),
        .dec_i      (dec_w),
        .clr_i      (clr_w),
        .cnt_o      (round_w),
        .zero_o     (zero_w)
    );

    // One decrypt round: v1 is unwound first, and the fresh v1 feeds the v0 update
    always_comb begin
        v1_d = v1_q - tea_mix(v0_q, sum_q, key_q[63:32], key_q[31:0]);
        v0_d = v0_q - tea_mix(v1_d, sum_q, key_q[127:96], key_q[95:64]);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            v0_q   <= '0;
            v1_q   <= '0;
            sum_q  <= '0;
            key_q  <= '0;
            pout_q <= '0;
        end else if (load_w) begin
            v0_q  <= CIN[63:32];
            v1_q  <= CIN[31:0];
            key_q <= KEY;
            sum_q <= SUM_INIT;
        end else if (BUSY) begin
            v0_q  <= v0_d;
            v1_q  <= v1_d;
            sum_q <= sum_q - DELTA;
            if (fin_w) begin
                pout_q <= {v0_d, v1_d};
            end
        end
    end

    assign POUT  = pout_q;
    assign ROUND = round_w;

endmodule

// File: tb/tb_tea_decrypt_core.sv
// Directed bench for tea_decrypt_core: known vector, START/KEY/CIN disturbance, mid-run reset,
// back-to-back operation and round trips through a bench-side TEA encrypt model.
module tb_tea_decrypt_core;

    logic         CLK;
    logic         RST_N;
    logic         START;
`ifdef TEA_DECRYPT_ABORT_EN
    logic         ABORT;
`endif
    logic [127:0] KEY;
    logic [63:0]  CIN;
    logic         READY, BUSY, DONE;
    logic [63:0]  POUT;
    logic [5:0]   ROUND;

    int n_checks = 0;
    int n_fail   = 0;

    tea_decrypt_core dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (START),
`ifdef TEA_DECRYPT_ABORT_EN
        .ABORT (ABORT),
`endif
        .KEY   (KEY),
        .CIN   (CIN),
        .READY (READY),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .POUT  (POUT),
        .ROUND (ROUND)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] tea_enc(input logic [127:0] k, input logic [63:0] p);
        logic [31:0] v0, v1, s;
        v0 = p[63:32];
        v1 = p[31:0];
        s  = 32'h0;
        for (int i = 0; i < 32; i++) begin
            s  = s + 32'h9E3779B9;
            v0 = v0 + (((v1 << 4) + k[127:96]) ^ (v1 + s) ^ ((v1 >> 5) + k[95:64]));
            v1 = v1 + (((v0 << 4) + k[63:32]) ^ (v0 + s) ^ ((v0 >> 5) + k[31:0]));
        end
        return {v0, v1};
    endfunction

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [63:0] rand_blk();
        return {$urandom, $urandom};
    endfunction

    // Called #1 after an edge; the START edge is edge 1, returns one edge after DONE
    task automatic do_op(input logic [127:0] k, input logic [63:0] c,
                         output logic [63:0] p, output int edges);
        KEY   = k;
        CIN   = c;
        START = 1'b1;
        edges = 0;
        p     = '0;
        for (int e = 1; e <= 60; e++) begin
            @(posedge CLK); #1;
            if (e == 1) START = 1'b0;
            if (DONE) begin
                edges = e;
                p     = POUT;
                break;
            end
        end
        @(posedge CLK); #1;
    endtask

    initial begin
        logic [127:0] k;
        logic [63:0]  pt, ct, p, last_pt;
        int           edges, n_done, done_edge, phase, exp_round;

        RST_N = 1'b0;
        START = 1'b0;
        KEY   = '0;
        CIN   = '0;
`ifdef TEA_DECRYPT_ABORT_EN
        ABORT = 1'b0;
`endif
        repeat (2) @(posedge CLK);
        #1;
        check("rst_ready", 64'(READY), 64'd1);
        check("rst_busy",  64'(BUSY),  64'd0);
        check("rst_done",  64'(DONE),  64'd0);
        check("rst_pout",  POUT,       64'd0);
        check("rst_round", 64'(ROUND), 64'd0);
        RST_N = 1'b1;

        // Known vector, started on the first edge after reset release
        KEY   = '0;
        CIN   = 64'h41EA3A0A_94BAA940;
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        check("kv_busy",   64'(BUSY),  64'd1);
        check("kv_ready",  64'(READY), 64'd0);
        check("kv_round0", 64'(ROUND), 64'd32);
        repeat (31) @(posedge CLK);
        #1;
        check("kv_round_last", 64'(ROUND), 64'd1);
        check("kv_done_early", 64'(DONE),  64'd0);
        @(posedge CLK); #1;
        check("kv_done",       64'(DONE),  64'd1);
        check("kv_pout",       POUT,       64'h0);
        check("kv_round_fin",  64'(ROUND), 64'd0);
        @(posedge CLK); #1;
        check("kv_done_pulse", 64'(DONE),  64'd0);
        check("kv_idle",       64'(READY), 64'd1);

        // Second START at edge 10 and KEY/CIN change at edge 5 must not disturb the run
        k  = rand_key();
        pt = rand_blk();
        ct = tea_enc(k, pt);
        KEY = k;
        CIN = ct;
        START = 1'b1;
        n_done = 0;
        done_edge = 0;
        p = '0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge CLK); #1;
            if (DONE) begin
                n_done++;
                done_edge = e;
                p = POUT;
            end
            if (e == 1) START = 1'b0;
            if (e == 4) begin
                KEY = rand_key();
                CIN = rand_blk();
            end
            if (e == 9)  START = 1'b1;
            if (e == 10) START = 1'b0;
        end
        check("dist_ndone", 64'(n_done),    64'd1);
        check("dist_edge",  64'(done_edge), 64'd33);
        check("dist_pout",  p,              pt);

        // Round trips through the encrypt model
        for (int i = 0; i < 1000; i++) begin
            k  = rand_key();
            pt = rand_blk();
            do_op(k, tea_enc(k, pt), p, edges);
            check($sformatf("rt%0d", i), p, pt);
            if (i == 0) check("rt_edges", 64'(edges), 64'd33);
        end

        // Reset in the middle of an operation
        k  = rand_key();
        pt = rand_blk();
        KEY = k;
        CIN = tea_enc(k, pt);
        START = 1'b1;
        for (int e = 1; e <= 17; e++) begin
            @(posedge CLK); #1;
            if (e == 1) START = 1'b0;
        end
        check("mid_busy", 64'(BUSY), 64'd1);
        RST_N = 1'b0;
        #1;
        check("mid_rst_ready", 64'(READY), 64'd1);
        check("mid_rst_busy",  64'(BUSY),  64'd0);
        check("mid_rst_done",  64'(DONE),  64'd0);
        check("mid_rst_pout",  POUT,       64'd0);
        check("mid_rst_round", 64'(ROUND), 64'd0);
        @(posedge CLK); #1;
        check("mid_rst_done2", 64'(DONE), 64'd0);
        RST_N = 1'b1;
        k  = rand_key();
        pt = rand_blk();
        do_op(k, tea_enc(k, pt), p, edges);
        check("post_rst_pout",  p,              pt);
        check("post_rst_edges", 64'(edges),     64'd33);

        // START held high: back-to-back operations every 34 edges
        k  = rand_key();
        pt = rand_blk();
        KEY = k;
        CIN = tea_enc(k, pt);
        START = 1'b1;
        for (int e = 1; e <= 102; e++) begin
            @(posedge CLK); #1;
            phase = (e - 1) % 34;
            exp_round = (phase < 32) ? 32 - phase : 0;
            check($sformatf("hold_round_e%0d", e), 64'(ROUND), 64'(exp_round));
            check($sformatf("hold_done_e%0d", e),  64'(DONE),  (phase == 32) ? 64'd1 : 64'd0);
            if (phase == 32) check($sformatf("hold_pout_e%0d", e), POUT, pt);
        end
        START = 1'b0;
        last_pt = pt;
        @(posedge CLK); #1;
        check("hold_stop_idle", 64'(READY), 64'd1);

`ifdef TEA_DECRYPT_ABORT_EN
        // ABORT raised after edge 20 returns to IDLE at edge 21 without DONE
        k  = rand_key();
        pt = rand_blk();
        KEY = k;
        CIN = tea_enc(k, pt);
        START = 1'b1;
        n_done = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge CLK); #1;
            if (DONE) n_done++;
            if (e == 1) START = 1'b0;
            if (e == 20) ABORT = 1'b1;
            if (e == 21) begin
                ABORT = 1'b0;
                check("abort_idle",  64'(READY), 64'd1);
                check("abort_round", 64'(ROUND), 64'd0);
            end
        end
        check("abort_ndone", 64'(n_done), 64'd0);
        check("abort_pout",  POUT,        last_pt);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tea_decrypt_core.md
TEA_DECRYPT_CORE -- requirements
Module: tea_decrypt_core

Interface
REQ-001 SHALL have parameter ROUNDS, default 32, number of decrypt rounds (legal 1..63).
REQ-002 SHALL have parameter DELTA, default 32'h9E3779B9, TEA key-schedule constant.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port START  input  1  request to decrypt; accepted only while READY=1.
REQ-006 SHALL have port KEY  input  128  key words k0..k3 = KEY[127:96], [95:64], [63:32], [31:0].
REQ-007 SHALL have port CIN  input  64  ciphertext; v0=CIN[63:32], v1=CIN[31:0].
REQ-008 SHALL have port READY  output  1  high in IDLE.
REQ-009 SHALL have port BUSY  output  1  high in RUN.
REQ-010 SHALL have port DONE  output  1  one-cycle pulse; POUT valid.
REQ-011 SHALL have port POUT  output  64  plaintext {v0,v1}.
REQ-012 SHALL have port ROUND  output  6  remaining-round count.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, FIN; transitions IDLE->RUN on START, RUN->FIN when ROUND==1 at the clock edge, FIN->IDLE unconditionally.
REQ-014 SHALL on START in IDLE latch CIN into v0/v1, KEY into key register, load sum = DELTA*ROUNDS mod 2^32 (32'hC6EF3720 at defaults), load ROUND = ROUNDS.
REQ-015 SHALL per RUN cycle compute, all mod 2^32: v1' = v1 - (((v0<<4)+k2) ^ (v0+sum) ^ ((v0>>5)+k3)); v0' = v0 - (((v1'<<4)+k0) ^ (v1'+sum) ^ ((v1'>>5)+k1)); sum' = sum - DELTA; ROUND' = ROUND - 1.
REQ-016 SHALL use logical (zero-fill) right shift and discard carries/borrows beyond 32 bits.
REQ-017 SHALL assert DONE exactly in FIN, i.e. in the cycle ROUNDS+1 edges after the START edge (33 at default).
REQ-018 SHALL update POUT only on the RUN->FIN edge and hold it until the next such edge.
REQ-019 SHALL ignore START in RUN and FIN; a START held high through FIN starts a new operation from IDLE on the following edge.
REQ-020 SHALL ignore KEY and CIN changes after the START edge.
REQ-021 SHALL decrement ROUND from ROUNDS to 0, never wrapping; ROUND reads 0 in FIN and IDLE.

Reset
REQ-022 SHALL on RST_N low immediately force IDLE, READY=1, BUSY=0, DONE=0, POUT=0, ROUND=0, and clear v0, v1, sum, and key registers.
REQ-023 SHALL abandon any operation in progress on reset, with no DONE pulse.
REQ-024 SHALL accept START on the first rising edge after RST_N deasserts.

Configuration
REQ-025 SHALL gate input ABORT (1 bit) with macro TEA_DECRYPT_ABORT_EN.
REQ-026 SHALL, with TEA_DECRYPT_ABORT_EN defined, return RUN to IDLE on the next edge when ABORT=1, with no DONE pulse, POUT unchanged, and ROUND=0; ABORT has priority over the RUN->FIN transition.
REQ-027 SHALL, without TEA_DECRYPT_ABORT_EN, omit the ABORT port, and every started operation completes.

Structure
REQ-028 SHALL take the state enum, the default DELTA, and the 32-bit round-function helper from the shared TEA package also used by the encrypt core.
REQ-029 SHALL place the round counter in sub-module mod33down: 6-bit load/decrement with a zero flag, the down-counting counterpart of the encrypt-side mod-33 counter.

Verification
REQ-030 SHALL apply KEY=0 and CIN=64'h41EA3A0A_94BAA940 with START -> DONE at edge 33, POUT=64'h0.
REQ-031 SHALL apply a random key and plaintext through the encrypt core, then decrypt -> POUT equals the original plaintext; 1000 iterations.
REQ-032 SHALL pulse START again at edge 10 and change KEY/CIN at edge 5 -> result unchanged, single DONE at edge 33.
REQ-033 SHALL assert RST_N low at edge 17 -> outputs at reset values immediately; next START gives a correct result.
REQ-034 SHALL hold START high continuously -> DONE every 34 cycles, ROUND sequence 32..1,0,0 repeating.
REQ-035 SHALL, with TEA_DECRYPT_ABORT_EN, assert ABORT at edge 20 -> IDLE at edge 21, no DONE, POUT retains the prior value.
